// File: rtl/the_data_memory_pkg.sv
// the_data_memory_pkg: shared sizing constants and types for the data memory.
package the_data_memory_pkg;
  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 1 << DMEM_ADDR_W;
  localparam int DMEM_PORTS  = 4;
  typedef logic [DMEM_ADDR_W-1:0] dmem_addr_t;
  typedef logic [DMEM_DATA_W-1:0] dmem_word_t;
endpackage

// File: rtl/the_data_memory_if.sv
// the_data_memory_if: four read ports and four write ports of the data memory.
interface the_data_memory_if;
  import the_data_memory_pkg::*;
  dmem_addr_t [DMEM_PORTS-1:0] data_rd;
  dmem_addr_t [DMEM_PORTS-1:0] data_wr;
  dmem_word_t [DMEM_PORTS-1:0] data_wr_data;
  logic       [DMEM_PORTS-1:0] data_wr_enable;
  dmem_word_t [DMEM_PORTS-1:0] data_rd_out;
  modport master (output data_rd, data_wr, data_wr_data, data_wr_enable, input data_rd_out);
  modport slave  (input data_rd, data_wr, data_wr_data, data_wr_enable, output data_rd_out);
endinterface

// File: rtl/dmem_write_merge.sv
// dmem_write_merge: per-word resolution of four write requests, highest port wins.
module dmem_write_merge
  import the_data_memory_pkg::*;
(
  input  dmem_addr_t [DMEM_PORTS-1:0] wr,
  input  dmem_word_t [DMEM_PORTS-1:0] wr_data,
  input  logic       [DMEM_PORTS-1:0] wr_enable,
  output logic       [DMEM_DEPTH-1:0] we,
  output dmem_word_t [DMEM_DEPTH-1:0] wd
);
  for (genvar w = 0; w < DMEM_DEPTH; w++) begin : g_word
    logic [DMEM_PORTS-1:0] hit;
    for (genvar p = 0; p < DMEM_PORTS; p++) begin : g_port
      assign hit[p] = wr_enable[p] && (wr[p] == dmem_addr_t'(w));
    end
    assign we[w] = |hit;
    assign wd[w] = hit[3] ? wr_data[3] : hit[2] ? wr_data[2] : hit[1] ? wr_data[1] : wr_data[0];
  end
endmodule

// File: rtl/the_data_memory.sv
// the_data_memory: 512x32 data memory, 4 combinational reads, 4 clocked writes, async clear.
module the_data_memory
  import the_data_memory_pkg::*;
(
  input  logic clock,
  input  logic reset,
  the_data_memory_if.slave bus
);
  dmem_word_t mem [DMEM_DEPTH];
  logic       [DMEM_DEPTH-1:0] we;
  dmem_word_t [DMEM_DEPTH-1:0] wd;
  dmem_write_merge u_merge (
    .wr        (bus.data_wr),
    .wr_data   (bus.data_wr_data),
    .wr_enable (bus.data_wr_enable),
    .we        (we),
    .wd        (wd)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
    else for (int i = 0; i < DMEM_DEPTH; i++) if (we[i]) mem[i] <= wd[i];
  always_comb begin
    bus.data_rd_out = '0;
    for (int n = 0; n < DMEM_PORTS; n++) bus.data_rd_out[n] = mem[bus.data_rd[n]];
  end
endmodule

// File: tb/tb_the_data_memory.sv
// tb_the_data_memory: directed vectors with a scoreboard queue checked by a separate monitor.
module tb_the_data_memory;
  import the_data_memory_pkg::*;
  logic clock = 0;
  logic reset = 0;
  the_data_memory_if bus ();
  the_data_memory dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {
    int         tag;
    int         port;
    dmem_word_t exp;
  } sb_t;
  sb_t  q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   tag = 0;
  event chk;
  initial forever begin
    @(chk);
    #1;
    while (q.size() > 0) begin
      sb_t e;
      e = q.pop_front();
      compared++;
      if (bus.data_rd_out[e.port] !== e.exp) begin
        mismatched++;
        $display("FAIL check%0d rd%0d: got %h want %h", e.tag, e.port + 1, bus.data_rd_out[e.port], e.exp);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic expect_rd(input int port, input int addr, input dmem_word_t val);
    sb_t e;
    bus.data_rd[port] = dmem_addr_t'(addr);
    e.tag = tag;
    e.port = port;
    e.exp = val;
    q.push_back(e);
    tag++;
  endtask
  task automatic probe();
    -> chk;
    #2;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic set_wr(input int port, input int addr, input dmem_word_t d, input logic en);
    bus.data_wr[port] = dmem_addr_t'(addr);
    bus.data_wr_data[port] = d;
    bus.data_wr_enable[port] = en;
  endtask
  initial begin
    bus.data_rd = '0;
    bus.data_wr = '0;
    bus.data_wr_data = '0;
    bus.data_wr_enable = '0;
    #1 reset = 1;
    tick();
    expect_rd(0, 0, 0); expect_rd(1, 1, 0); expect_rd(2, 255, 0); expect_rd(3, 511, 0);
    probe();
    tick();
    reset = 0;
    tick();
    expect_rd(0, 0, 0); expect_rd(1, 1, 0); expect_rd(2, 255, 0); expect_rd(3, 511, 0);
    probe();
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) expect_rd(p, int'($urandom_range(0, 511)), 0);
      probe();
    end
    set_wr(0, 5, 32'hDEADBEEF, 1);
    expect_rd(1, 5, 32'h0);
    probe();
    tick();
    bus.data_wr_enable = '0;
    expect_rd(1, 5, 32'hDEADBEEF);
    probe();
    set_wr(0, 10, 32'd1, 1); set_wr(1, 11, 32'd2, 1); set_wr(2, 12, 32'd3, 1); set_wr(3, 13, 32'd4, 1);
    tick();
    bus.data_wr_enable = '0;
    expect_rd(0, 10, 32'd1); expect_rd(1, 11, 32'd2); expect_rd(2, 12, 32'd3); expect_rd(3, 13, 32'd4);
    probe();
    expect_rd(0, 5, 32'hDEADBEEF);
    probe();
    set_wr(0, 20, 32'hAAAA0001, 1); set_wr(1, 20, 32'hBBBB0002, 1);
    set_wr(2, 20, 32'hCCCC0003, 1); set_wr(3, 20, 32'hDDDD0004, 1);
    tick();
    expect_rd(0, 20, 32'hDDDD0004);
    probe();
    if (bus.data_rd_out[0] !== 32'hDDDD0004) begin
      mismatched++;
      $display("FAIL direct priority: got %h want DDDD0004", bus.data_rd_out[0]);
    end
    bus.data_wr_enable[3] = 0;
    tick();
    bus.data_wr_enable = '0;
    expect_rd(0, 20, 32'hCCCC0003);
    probe();
    set_wr(0, 511, 32'h12345678, 1); set_wr(1, 0, 32'h12345678, 1);
    tick();
    bus.data_wr_enable = '0;
    for (int p = 0; p < 4; p++) expect_rd(p, 511, 32'h12345678);
    probe();
    expect_rd(0, 0, 32'h12345678); expect_rd(1, 13, 32'd4);
    probe();
    set_wr(0, 10, 32'hFFFFFFFF, 0); set_wr(3, 11, 32'hFFFFFFFF, 0);
    tick();
    expect_rd(0, 10, 32'd1); expect_rd(1, 11, 32'd2);
    probe();
    tick();
    #2 reset = 1;
    for (int p = 0; p < 4; p++) expect_rd(p, 10 + p, 0);
    probe();
    if (bus.data_rd_out[0] !== 32'h0) begin
      mismatched++;
      $display("FAIL direct async reset: got %h want 0", bus.data_rd_out[0]);
    end
    expect_rd(0, 511, 0); expect_rd(1, 5, 0);
    probe();
    set_wr(0, 7, 32'h00000055, 1);
    tick();
    tick();
    #2 reset = 0;
    bus.data_wr_enable = '0;
    tick();
    expect_rd(0, 7, 0); expect_rd(1, 20, 0);
    probe();
    set_wr(2, 7, 32'h0000AAAA, 1);
    expect_rd(0, 7, 0);
    probe();
    tick();
    bus.data_wr_enable = '0;
    expect_rd(0, 7, 32'h0000AAAA);
    probe();
    if (bus.data_rd_out[0] !== 32'h0000AAAA) begin
      mismatched++;
      $display("FAIL direct post-reset write: got %h want 0000AAAA", bus.data_rd_out[0]);
    end
    if (compared == 0) begin
      mismatched++;
      $display("FAIL no scoreboard comparisons performed");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
